// File: rtl/decode_pkg.sv
// Decode-stage definitions: widths, instruction field positions, opcode set and the
// registered bundle handed to execute.
package decode_pkg;

   localparam int NUM_REG     = 32;
   localparam int LEN_INSN    = 32;
   localparam int LEN_ADDR    = $clog2(NUM_REG);
   localparam int LEN_OPECODE = 6;
   localparam int LEN_IMMF    = 1;
   localparam int LEN_CC      = 4;
   localparam int LEN_REG     = 32;
   localparam int LEN_IMM     = 16;
   localparam int LEN_IMM_EX  = 32;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int IMMF_BIT = 25;
   localparam int CC_MSB   = 24;
   localparam int CC_LSB   = 21;
   localparam int RD_MSB   = 20;
   localparam int RD_LSB   = 16;
   localparam int RS_MSB   = 15;
   localparam int RS_LSB   = 11;
   localparam int IMM_MSB  = 15;
   localparam int IMM_LSB  = 0;

   typedef logic [LEN_OPECODE-1:0] opecode_t;

   localparam opecode_t OPECODE_NOP  = 6'h00;
   localparam opecode_t OPECODE_ADD  = 6'h01;
   localparam opecode_t OPECODE_SUB  = 6'h02;
   localparam opecode_t OPECODE_AND  = 6'h03;
   localparam opecode_t OPECODE_OR   = 6'h04;
   localparam opecode_t OPECODE_XOR  = 6'h05;
   localparam opecode_t OPECODE_SHL  = 6'h06;
   localparam opecode_t OPECODE_SHR  = 6'h07;
   localparam opecode_t OPECODE_LD   = 6'h08;
   localparam opecode_t OPECODE_ST   = 6'h09;
   localparam opecode_t OPECODE_BR   = 6'h10;
   localparam opecode_t OPECODE_JMP  = 6'h11;
   localparam opecode_t OPECODE_HALT = 6'h3F;

   typedef struct packed {
      opecode_t              opecode;
      logic [LEN_IMMF-1:0]   immf;
      logic [LEN_CC-1:0]     cc;
      logic [LEN_ADDR-1:0]   rd_addr;
      logic [LEN_REG-1:0]    data_rd;
      logic [LEN_REG-1:0]    data_rs;
      logic [LEN_IMM_EX-1:0] imm_ex;
      logic                  illegal;
   } bundle_t;

   function automatic logic opecode_legal(input opecode_t opc);
      logic legal;
      case (opc)
         OPECODE_NOP, OPECODE_ADD, OPECODE_SUB, OPECODE_AND, OPECODE_OR,
         OPECODE_XOR, OPECODE_SHL, OPECODE_SHR, OPECODE_LD, OPECODE_ST,
         OPECODE_BR, OPECODE_JMP, OPECODE_HALT: legal = 1'b1;
         default:                               legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic [LEN_IMM_EX-1:0] sign_ext(input logic [LEN_IMM-1:0] imm);
      return {{(LEN_IMM_EX-LEN_IMM){imm[LEN_IMM-1]}}, imm};
   endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch->decode->execute handshake plus writeback port; master is the surrounding pipeline,
// slave is the decode stage.
interface decode_if;
   import decode_pkg::*;

   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [LEN_INSN-1:0]   insn;

   logic                  out_valid;
   logic                  out_ready;
   opecode_t              opecode;
   logic [LEN_IMMF-1:0]   immf;
   logic [LEN_CC-1:0]     cc;
   logic [LEN_ADDR-1:0]   rd_addr;
   logic [LEN_REG-1:0]    data_rd;
   logic [LEN_REG-1:0]    data_rs;
   logic [LEN_IMM_EX-1:0] imm_ex;
   logic                  illegal;

   logic                  wb_en;
   logic [LEN_ADDR-1:0]   wb_addr;
   logic [LEN_REG-1:0]    wb_data;

   modport master (
      output flush, in_valid, insn, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, opecode, immf, cc, rd_addr, data_rd, data_rs, imm_ex, illegal
   );

   modport slave (
      input  flush, in_valid, insn, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, opecode, immf, cc, rd_addr, data_rd, data_rs, imm_ex, illegal
   );

endinterface

// File: rtl/decode_regfile.sv
// Register file: two async read ports, one sync write port, r0 hardwired to zero, sync clear.
// With DECODE_WB_FWD_EN a read of the address being written returns the incoming data.
module decode_regfile
   import decode_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [LEN_ADDR-1:0] ra_addr,
   output logic [LEN_REG-1:0]  ra_data,
   input  logic [LEN_ADDR-1:0] rb_addr,
   output logic [LEN_REG-1:0]  rb_data,
   input  logic                wb_en,
   input  logic [LEN_ADDR-1:0] wb_addr,
   input  logic [LEN_REG-1:0]  wb_data
);

   logic [LEN_REG-1:0] regs [NUM_REG];
   logic               wr_live;

   assign wr_live = wb_en && (wb_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
      rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];
`ifdef DECODE_WB_FWD_EN
      if (wr_live && (wb_addr == ra_addr)) begin
         ra_data = wb_data;
      end
      if (wr_live && (wb_addr == rb_addr)) begin
         rb_data = wb_data;
      end
`endif
   end

endmodule

// File: rtl/decode.sv
// Decode/operand fetch: 1-cycle latency to a registered bundle; in_ready = !out_valid || out_ready,
// bundle holds while execute stalls. DECODE_WB_FWD_EN enables writeback forwarding into reads and the held bundle.
module decode
   import decode_pkg::*;
(
   input logic     clk,
   input logic     rst,
   decode_if.slave bus
);

   logic                out_valid_q;
   bundle_t             bundle_q;
   bundle_t             bundle_d;
   logic                accept;
   logic [LEN_ADDR-1:0] rd_sel;
   logic [LEN_ADDR-1:0] rs_sel;
   logic [LEN_REG-1:0]  rd_val;
   logic [LEN_REG-1:0]  rs_val;
`ifdef DECODE_WB_FWD_EN
   logic [LEN_ADDR-1:0] rs_addr_q;
`endif

   assign rd_sel = bus.insn[RD_MSB:RD_LSB];
   assign rs_sel = bus.insn[RS_MSB:RS_LSB];

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   decode_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (rd_sel),
      .ra_data (rd_val),
      .rb_addr (rs_sel),
      .rb_data (rs_val),
      .wb_en   (bus.wb_en),
      .wb_addr (bus.wb_addr),
      .wb_data (bus.wb_data)
   );

   always_comb begin
      bundle_d         = '0;
      bundle_d.opecode = bus.insn[OPC_MSB:OPC_LSB];
      bundle_d.immf    = bus.insn[IMMF_BIT];
      bundle_d.cc      = bus.insn[CC_MSB:CC_LSB];
      bundle_d.rd_addr = rd_sel;
      bundle_d.data_rd = rd_val;
      bundle_d.data_rs = rs_val;
      bundle_d.imm_ex  = sign_ext(bus.insn[IMM_MSB:IMM_LSB]);
      bundle_d.illegal = !opecode_legal(bus.insn[OPC_MSB:OPC_LSB]);
   end

   // Priority: reset, flush, new accept, drain; otherwise the bundle is stalled and holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
`ifdef DECODE_WB_FWD_EN
         rs_addr_q   <= '0;
`endif
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= bundle_d;
`ifdef DECODE_WB_FWD_EN
         rs_addr_q   <= rs_sel;
`endif
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
`ifdef DECODE_WB_FWD_EN
      end else if (out_valid_q && bus.wb_en && (bus.wb_addr != '0)) begin
         if (bus.wb_addr == bundle_q.rd_addr) begin
            bundle_q.data_rd <= bus.wb_data;
         end
         if (bus.wb_addr == rs_addr_q) begin
            bundle_q.data_rs <= bus.wb_data;
         end
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.opecode   = bundle_q.opecode;
   assign bus.immf      = bundle_q.immf;
   assign bus.cc        = bundle_q.cc;
   assign bus.rd_addr   = bundle_q.rd_addr;
   assign bus.data_rd   = bundle_q.data_rd;
   assign bus.data_rs   = bundle_q.data_rs;
   assign bus.imm_ex    = bundle_q.imm_ex;
   assign bus.illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed vector table, handshake/flush/forwarding sequences, then random
// traffic checked against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_decode;
   import decode_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_if bus();
   decode dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DECODE_WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic [31:0] insn;
      logic [5:0]  opc;
      logic        immf;
      logic [3:0]  cc;
      logic [4:0]  rd;
      logic [31:0] data_rd;
      logic [31:0] data_rs;
      logic [31:0] imm_ex;
      logic        illegal;
   } vec_t;

   vec_t tbl [5];
   vec_t zero_v;
   int   n_vec = 0;
   int   n_bad = 0;

   opecode_t legal_ops [13] = '{OPECODE_NOP, OPECODE_ADD, OPECODE_SUB, OPECODE_AND, OPECODE_OR,
                                OPECODE_XOR, OPECODE_SHL, OPECODE_SHR, OPECODE_LD, OPECODE_ST,
                                OPECODE_BR, OPECODE_JMP, OPECODE_HALT};

   // Reference model state
   logic        m_valid;
   vec_t        m_b;
   logic [4:0]  m_rs;
   logic [31:0] m_rf [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input vec_t e);
      chk($sformatf("%s opecode", tag), 32'(bus.opecode), 32'(e.opc));
      chk($sformatf("%s immf", tag),    32'(bus.immf),    32'(e.immf));
      chk($sformatf("%s cc", tag),      32'(bus.cc),      32'(e.cc));
      chk($sformatf("%s rd_addr", tag), 32'(bus.rd_addr), 32'(e.rd));
      chk($sformatf("%s data_rd", tag), bus.data_rd,      e.data_rd);
      chk($sformatf("%s data_rs", tag), bus.data_rs,      e.data_rs);
      chk($sformatf("%s imm_ex", tag),  bus.imm_ex,       e.imm_ex);
      chk($sformatf("%s illegal", tag), 32'(bus.illegal), 32'(e.illegal));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      bus.wb_en   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
      tick();
      bus.wb_en   = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a, input logic wen,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (FWD && wen && (wa == a)) return wd;
      return m_rf[a];
   endfunction

   function automatic vec_t m_decode(input logic [31:0] w, input logic wen,
                                     input logic [4:0] wa, input logic [31:0] wd);
      vec_t v;
      int   s;
      v.insn    = w;
      v.opc     = 6'(w / 32'h0400_0000);
      v.immf    = 1'((w >> 25) % 2);
      v.cc      = 4'((w >> 21) % 16);
      v.rd      = 5'((w >> 16) % 32);
      v.data_rd = m_read(v.rd, wen, wa, wd);
      v.data_rs = m_read(5'((w >> 11) % 32), wen, wa, wd);
      s = int'(w % 65536);
      if (s >= 32768) s = s - 65536;
      v.imm_ex  = 32'(s);
      v.illegal = 1'b1;
      foreach (legal_ops[k]) if (legal_ops[k] == v.opc) v.illegal = 1'b0;
      return v;
   endfunction

   task automatic m_step();
      logic rdy;
      rdy = !m_valid || bus.out_ready;
      if (rst) begin
         m_valid = 1'b0;
         foreach (m_rf[i]) m_rf[i] = 32'd0;
      end else begin
         if (bus.flush) begin
            m_valid = 1'b0;
         end else if (bus.in_valid && rdy) begin
            m_b     = m_decode(bus.insn, bus.wb_en, bus.wb_addr, bus.wb_data);
            m_rs    = 5'((bus.insn >> 11) % 32);
            m_valid = 1'b1;
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end else if (FWD && m_valid && bus.wb_en && (bus.wb_addr != 5'd0)) begin
            if (bus.wb_addr == m_b.rd) m_b.data_rd = bus.wb_data;
            if (bus.wb_addr == m_rs)   m_b.data_rs = bus.wb_data;
         end
         if (bus.wb_en && (bus.wb_addr != 5'd0)) m_rf[bus.wb_addr] = bus.wb_data;
      end
   endtask

   initial begin
      tbl[0] = '{32'h0403_2000, 6'h01, 1'b0, 4'h0, 5'd3,  32'h1234_0000, 32'h0000_5678, 32'h0000_2000, 1'b0};
      tbl[1] = '{32'h0AA4_FFF0, 6'h02, 1'b1, 4'h5, 5'd4,  32'h0000_5678, 32'hCAFE_F00D, 32'hFFFF_FFF0, 1'b0};
      tbl[2] = '{32'h13E0_7FFF, 6'h04, 1'b1, 4'hF, 5'd0,  32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_7FFF, 1'b0};
      tbl[3] = '{32'hA803_8000, 6'h2A, 1'b0, 4'h0, 5'd3,  32'h1234_0000, 32'h8000_0001, 32'hFFFF_8000, 1'b1};
      tbl[4] = '{32'hFD3F_1800, 6'h3F, 1'b0, 4'h9, 5'd31, 32'hCAFE_F00D, 32'h1234_0000, 32'h0000_1800, 1'b0};
      zero_v = '{32'd0, 6'd0, 1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0};

      // Reset held two cycles with an insn offered
      rst = 1'b1;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      bus.in_valid = 1'b1; bus.insn = tbl[0].insn;
      @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk_out("reset", zero_v);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);
      chk("post-reset out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("first accept out_valid", 32'(bus.out_valid), 32'd1);
      chk("cleared rf data_rd", bus.data_rd, 32'd0);
      chk("cleared rf data_rs", bus.data_rs, 32'd0);
      tick();

      // Preload the register file, including an ignored write to r0
      wb(5'd3, 32'h1234_0000);
      wb(5'd4, 32'h0000_5678);
      wb(5'd31, 32'hCAFE_F00D);
      wb(5'd15, 32'h0F0F_0F0F);
      wb(5'd16, 32'h8000_0001);
      wb(5'd0, 32'hFFFF_FFFF);

      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.insn     = tbl[i].insn;
         tick();
         bus.in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("tbl%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         chk_out($sformatf("tbl%0d", i), tbl[i]);
         tick();
      end

      // Stall for three cycles, then release into back-to-back bundles
      bus.in_valid = 1'b1; bus.insn = tbl[0].insn; bus.out_ready = 1'b0;
      tick();
      bus.insn = tbl[4].insn;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
         chk($sformatf("stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
         chk_out($sformatf("stall%0d", k), tbl[0]);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.insn = tbl[1].insn;
      @(negedge clk);
      chk("b2b first out_valid", 32'(bus.out_valid), 32'd1);
      chk_out("b2b first", tbl[4]);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("b2b second out_valid", 32'(bus.out_valid), 32'd1);
      chk_out("b2b second", tbl[1]);
      tick();
      @(negedge clk);
      chk("drained out_valid", 32'(bus.out_valid), 32'd0);

      // Flush while a bundle is held and another insn is offered
      bus.in_valid = 1'b1; bus.insn = tbl[0].insn; bus.out_ready = 1'b0;
      tick();
      bus.flush = 1'b1; bus.insn = tbl[3].insn;
      @(negedge clk);
      chk("pre-flush out_valid", 32'(bus.out_valid), 32'd1);
      tick();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("flushed insn dropped", 32'(bus.out_valid), 32'd0);
      tick();

      // Same-cycle writeback and read
      wb(5'd5, 32'h0000_0055);
      bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
      bus.in_valid = 1'b1; bus.insn = 32'h0405_2800;
      tick();
      bus.wb_en = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("wb same-cycle data_rd", bus.data_rd, FWD ? 32'hDEAD_BEEF : 32'h0000_0055);
      chk("wb same-cycle data_rs", bus.data_rs, FWD ? 32'hDEAD_BEEF : 32'h0000_0055);
      tick();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
      bus.in_valid = 1'b1; bus.insn = 32'h0400_0000;
      tick();
      bus.wb_en = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("r0 write data_rd", bus.data_rd, 32'd0);
      chk("r0 write data_rs", bus.data_rs, 32'd0);
      tick();

      // Writeback to the operands of a stalled bundle
      bus.in_valid = 1'b1; bus.insn = 32'h0405_2800; bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("held pre-wb data_rd", bus.data_rd, 32'hDEAD_BEEF);
      wb(5'd5, 32'h0BAD_F00D);
      @(negedge clk);
      chk("held wb data_rd", bus.data_rd, FWD ? 32'h0BAD_F00D : 32'hDEAD_BEEF);
      chk("held wb data_rs", bus.data_rs, FWD ? 32'h0BAD_F00D : 32'hDEAD_BEEF);
      chk("held wb out_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      tick();

      // Random traffic against the model; first cycle is a reset to sync the model
      m_valid = 1'b0;
      m_b     = zero_v;
      m_rs    = '0;
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] w;
         rst           = (c == 0) || ($urandom_range(0, 99) == 0);
         bus.flush     = ($urandom_range(0, 9) == 0);
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         w             = $urandom;
         w[20:16]      = 5'($urandom_range(0, 7));
         w[15:11]      = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) w[31:26] = legal_ops[$urandom_range(0, 12)];
         bus.insn      = w;
         bus.wb_en     = 1'($urandom_range(0, 1));
         bus.wb_addr   = 5'($urandom_range(0, 7));
         bus.wb_data   = $urandom;
         @(negedge clk);
         if (c > 0) begin
            chk("rnd in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            chk("rnd out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) chk_out($sformatf("rnd c%0d", c), m_b);
         end
         m_step();
         tick();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
